rom_loader: RTL and testbench

//  Writer side of the instruction ROM's write port. Consumes a byte stream (UART rx bytes)

---
 rtl/rom_loader_pkg.sv | 15 +
 rtl/rom_loader_if.sv | 25 ++
 rtl/rom_loader_byte_packer.sv | 39 +++
 rtl/rom_loader.sv | 154 +++++++++++++++
 tb/tb_rom_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/rom_loader_pkg.sv
// Shared sizes and loader state encodings for the instruction ROM writer.
package rom_loader_pkg;

    localparam int unsigned ROM_NUM       = 4096;
    localparam int unsigned INST_ADDR_BUS = 32;
    localparam int unsigned INST_DATA_BUS = 32;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LEN  = 2'd1,
        LD_DATA = 2'd2,
        LD_CSUM = 2'd3
    } ld_state_e;

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write-port output bundle of the loader.
interface rom_loader_if;
    import rom_loader_pkg::*;

    logic                     start_i;
    logic [7:0]               byte_i;
    logic                     byte_vld_i;
    logic                     wr_en_o;
    logic [INST_ADDR_BUS-1:0] wr_addr_o;
    logic [INST_DATA_BUS-1:0] wr_data_o;
    logic                     busy_o;
    logic                     cpu_hold_o;
    logic                     done_o;
    logic                     err_o;

    modport master (
        output start_i, byte_i, byte_vld_i,
        input  wr_en_o, wr_addr_o, wr_data_o, busy_o, cpu_hold_o, done_o, err_o
    );

    modport slave (
        input  start_i, byte_i, byte_vld_i,
        output wr_en_o, wr_addr_o, wr_data_o, busy_o, cpu_hold_o, done_o, err_o
    );
endinterface

// File: rtl/rom_loader_byte_packer.sv
// Packs payload bytes little-endian into 32-bit words; flushes on lane 3 or last byte.
module rom_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_vld,
    input  logic        i_last,
    input  logic [7:0]  i_byte,
    output logic        o_flush,
    output logic [31:0] o_word
);
    logic [1:0]  r_lane;
    logic [31:0] r_word;
    logic [31:0] w_merged;

    always_comb begin
        w_merged = r_word;
        w_merged[{r_lane, 3'b000} +: 8] = i_byte;
    end

    // The flushed word comes straight from the merge so unfilled lanes stay zero.
    assign o_word  = w_merged;
    assign o_flush = i_vld && !i_clear && ((r_lane == 2'd3) || i_last);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_lane <= 2'd0;
            r_word <= 32'd0;
        end else if (i_vld) begin
            if (o_flush) begin
                r_lane <= 2'd0;
                r_word <= 32'd0;
            end else begin
                r_lane <= r_lane + 2'd1;
                r_word <= w_merged;
            end
        end
    end
endmodule

// File: rtl/rom_loader.sv
// Frame parser (length, payload, checksum) that writes the program image into the ROM.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_BYTES      = ROM_NUM * 4,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input logic        clk,
    input logic        rst,
    rom_loader_if.slave bus
);
    localparam logic [31:0] MAX_LEN  = 32'(MAX_BYTES);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    ld_state_e   r_state;
    ld_state_e   w_next;
    logic [31:0] r_len;
    logic [31:0] r_cnt;
    logic [31:0] r_idx;
    logic [31:0] r_tmo;
    logic [7:0]  r_csum;
    logic        r_err;
    logic        r_done;
    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;

    logic        w_busy;
    logic        w_acc;
    logic        w_last;
    logic        w_tmo;
    logic        w_set_err;
    logic        w_set_done;
    logic        w_ins;
    logic        w_pk_clear;
    logic        w_pk_flush;
    logic [31:0] w_pk_word;
    logic [31:0] w_len_next;

    assign w_busy     = (r_state != LD_IDLE);
    assign w_acc      = bus.byte_vld_i && !bus.start_i && w_busy;
    assign w_last     = (r_cnt == (r_len - 32'd1));
    assign w_tmo      = w_busy && !bus.start_i && !w_acc && (r_tmo == TMO_LAST);
    assign w_len_next = {bus.byte_i, r_len[31:8]};
    assign w_pk_clear = bus.start_i || w_tmo;

    always_ff @(posedge clk) begin
        if (rst) r_state <= LD_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_set_err  = 1'b0;
        w_set_done = 1'b0;
        w_ins      = 1'b0;
        if (bus.start_i) begin
            w_next = LD_LEN;
        end else if (w_tmo) begin
            w_next    = LD_IDLE;
            w_set_err = 1'b1;
        end else if (w_acc) begin
            case (r_state)
                LD_LEN: begin
                    if (r_cnt == 32'd3) begin
                        if (w_len_next > MAX_LEN) begin
                            w_next    = LD_IDLE;
                            w_set_err = 1'b1;
                        end else if (w_len_next == 32'd0) begin
                            w_next = LD_CSUM;
                        end else begin
                            w_next = LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    w_ins = 1'b1;
                    if (w_last) w_next = LD_CSUM;
                end
                LD_CSUM: begin
                    w_next = LD_IDLE;
                    if (bus.byte_i == r_csum) w_set_done = 1'b1;
                    else                      w_set_err  = 1'b1;
                end
                default: w_next = LD_IDLE;
            endcase
        end
    end

    rom_loader_byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_pk_clear),
        .i_vld   (w_ins),
        .i_last  (w_last),
        .i_byte  (bus.byte_i),
        .o_flush (w_pk_flush),
        .o_word  (w_pk_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= 32'd0;
            r_cnt     <= 32'd0;
            r_idx     <= 32'd0;
            r_tmo     <= 32'd0;
            r_csum    <= 8'd0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= BASE_ADDR;
            r_wr_data <= 32'd0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= w_set_done;

            if (bus.start_i || w_acc || !w_busy) r_tmo <= 32'd0;
            else                                 r_tmo <= r_tmo + 32'd1;

            if (bus.start_i) begin
                r_err  <= 1'b0;
                r_len  <= 32'd0;
                r_cnt  <= 32'd0;
                r_idx  <= 32'd0;
                r_csum <= 8'd0;
            end else begin
                if (w_set_err) r_err <= 1'b1;
                if (w_acc && r_state == LD_LEN) begin
                    r_len <= w_len_next;
                    r_cnt <= (r_cnt == 32'd3) ? 32'd0 : r_cnt + 32'd1;
                end
                if (w_ins) begin
                    r_csum <= r_csum + bus.byte_i;
                    r_cnt  <= r_cnt + 32'd1;
                end
                if (w_pk_flush) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= BASE_ADDR + (r_idx << 2);
                    r_wr_data <= w_pk_word;
                    r_idx     <= r_idx + 32'd1;
                end
            end
        end
    end

    assign bus.wr_en_o    = r_wr_en;
    assign bus.wr_addr_o  = r_wr_addr;
    assign bus.wr_data_o  = r_wr_data;
    assign bus.busy_o     = w_busy;
    assign bus.cpu_hold_o = w_busy;
    assign bus.done_o     = r_done;
    assign bus.err_o      = r_err;
endmodule

// File: tb/tb_rom_loader.sv
// Directed frames against rom_loader: good, short-tail, bad checksum, oversize, timeout, abort.
module tb_rom_loader;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   done_cnt;
    int   wbase;
    int   dbase;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    logic [7:0] p1 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] p2 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    rom_loader_if ifc ();

    rom_loader #(
        .BASE_ADDR      (32'h0000_0000),
        .MAX_BYTES      (64),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifc.wr_en_o) begin
            wa.push_back(ifc.wr_addr_o);
            wd.push_back(ifc.wr_data_o);
        end
        if (ifc.done_o) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_write(input string tag, input int i, input logic [31:0] addr, input logic [31:0] data);
        if (wbase + i < wa.size()) begin
            check({tag, "_addr"}, wa[wbase + i], addr);
            check({tag, "_data"}, wd[wbase + i], data);
        end else begin
            check({tag, "_missing"}, 32'(wa.size() - wbase), 32'(i + 1));
        end
    endtask

    task automatic mark();
        wbase = wa.size();
        dbase = done_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ifc.start_i = 1'b1;
        @(negedge clk);
        ifc.start_i = 1'b0;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ifc.byte_i     = b;
        ifc.byte_vld_i = 1'b1;
        @(negedge clk);
        ifc.byte_vld_i = 1'b0;
        #1;
    endtask

    task automatic send_len(input logic [31:0] l);
        send_byte(l[7:0]);
        send_byte(l[15:8]);
        send_byte(l[23:16]);
        send_byte(l[31:24]);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        rst = 1'b1;
        ifc.start_i    = 1'b0;
        ifc.byte_i     = 8'h00;
        ifc.byte_vld_i = 1'b0;
        idle(3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wr_en",   32'(ifc.wr_en_o), 32'd0);
        check("rst_wr_addr", ifc.wr_addr_o, 32'h0);
        check("rst_wr_data", ifc.wr_data_o, 32'h0);
        check("rst_busy",    32'(ifc.busy_o), 32'd0);
        check("rst_done",    32'(ifc.done_o), 32'd0);
        check("rst_err",     32'(ifc.err_o), 32'd0);

        // 1) two full words
        mark();
        pulse_start();
        check("t1_busy_start", 32'(ifc.busy_o), 32'd1);
        check("t1_hold_start", 32'(ifc.cpu_hold_o), 32'd1);
        send_len(32'd8);
        for (int i = 0; i < 8; i++) send_byte(p1[i]);
        check("t1_hold_csum", 32'(ifc.cpu_hold_o), 32'd1);
        send_byte(8'h64);
        check("t1_nwr",  32'(wa.size() - wbase), 32'd2);
        check_write("t1_w0", 0, 32'h0, 32'h4433_2211);
        check_write("t1_w1", 1, 32'h4, 32'h8877_6655);
        check("t1_done", 32'(done_cnt - dbase), 32'd1);
        check("t1_err",  32'(ifc.err_o), 32'd0);
        check("t1_hold_end", 32'(ifc.cpu_hold_o), 32'd0);

        // 2) partial last word, zero-filled upper lanes
        mark();
        pulse_start();
        send_len(32'd5);
        for (int i = 0; i < 5; i++) send_byte(p2[i]);
        send_byte(8'hFC);
        check("t2_nwr", 32'(wa.size() - wbase), 32'd2);
        check_write("t2_w0", 0, 32'h0, 32'hDDCC_BBAA);
        check_write("t2_w1", 1, 32'h4, 32'h0000_00EE);
        check("t2_done", 32'(done_cnt - dbase), 32'd1);
        check("t2_err",  32'(ifc.err_o), 32'd0);

        // 3) bad checksum: write stays, err sticky
        mark();
        pulse_start();
        send_len(32'd4);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hFF);
        check("t3_nwr", 32'(wa.size() - wbase), 32'd1);
        check_write("t3_w0", 0, 32'h0, 32'h0403_0201);
        check("t3_done", 32'(done_cnt - dbase), 32'd0);
        idle(5);
        check("t3_err_sticky", 32'(ifc.err_o), 32'd1);
        check("t3_busy", 32'(ifc.busy_o), 32'd0);

        // 4) oversize length
        mark();
        pulse_start();
        check("t4_err_cleared", 32'(ifc.err_o), 32'd0);
        send_len(32'd68);
        check("t4_err",  32'(ifc.err_o), 32'd1);
        check("t4_busy", 32'(ifc.busy_o), 32'd0);
        send_byte(8'h55);
        idle(2);
        check("t4_nwr", 32'(wa.size() - wbase), 32'd0);

        // 5) timeout after 3 payload bytes, then recovery
        mark();
        pulse_start();
        send_len(32'd8);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        idle(90);
        check("t5_err_early", 32'(ifc.err_o), 32'd0);
        check("t5_busy_early", 32'(ifc.busy_o), 32'd1);
        idle(15);
        check("t5_err_tmo",  32'(ifc.err_o), 32'd1);
        check("t5_busy_tmo", 32'(ifc.busy_o), 32'd0);
        check("t5_nwr_tmo",  32'(wa.size() - wbase), 32'd0);
        pulse_start();
        check("t5_err_clr", 32'(ifc.err_o), 32'd0);
        send_len(32'd4);
        send_byte(8'hA0); send_byte(8'hB0); send_byte(8'hC0); send_byte(8'hD0);
        send_byte(8'hE0);
        check("t5_nwr", 32'(wa.size() - wbase), 32'd1);
        check_write("t5_w0", 0, 32'h0, 32'hD0C0_B0A0);
        check("t5_done", 32'(done_cnt - dbase), 32'd1);
        check("t5_err_end", 32'(ifc.err_o), 32'd0);

        // 6a) start mid-DATA, coincident with a byte that must be dropped
        mark();
        pulse_start();
        send_len(32'd8);
        send_byte(8'h11); send_byte(8'h22);
        @(negedge clk);
        ifc.start_i    = 1'b1;
        ifc.byte_vld_i = 1'b1;
        ifc.byte_i     = 8'hFF;
        @(negedge clk);
        ifc.start_i    = 1'b0;
        ifc.byte_vld_i = 1'b0;
        #1;
        check("t6a_busy", 32'(ifc.busy_o), 32'd1);
        check("t6a_err",  32'(ifc.err_o), 32'd0);
        idle(10);
        check("t6a_nwr_abort", 32'(wa.size() - wbase), 32'd0);
        send_len(32'd4);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0A);
        check("t6a_nwr", 32'(wa.size() - wbase), 32'd1);
        check_write("t6a_w0", 0, 32'h0, 32'h0403_0201);
        check("t6a_done", 32'(done_cnt - dbase), 32'd1);
        check("t6a_err_end", 32'(ifc.err_o), 32'd0);

        // 6b) reset with a partial word pending
        mark();
        pulse_start();
        send_len(32'd8);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        send_byte(8'h09);
        check("t6b_nwr_pre", 32'(wa.size() - wbase), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6b_wr_addr", ifc.wr_addr_o, 32'h0);
        check("t6b_wr_data", ifc.wr_data_o, 32'h0);
        check("t6b_busy",    32'(ifc.busy_o), 32'd0);
        check("t6b_err",     32'(ifc.err_o), 32'd0);
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
        idle(10);
        check("t6b_nwr_post", 32'(wa.size() - wbase), 32'd1);
        check("t6b_done",     32'(done_cnt - dbase), 32'd0);
        check("t6b_busy_end", 32'(ifc.busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
